// File: rtl/mem_arbiter.sv
// mem_arbiter: memory-side responder for the icache/dcache control interface.
// Serves CPUS dcaches and CPUS icaches through one single-ported RAM. Class
// priority is dcache write > dcache read > icache read, with round-robin across
// CPUs inside a class. The two words of a dcache block transfer stay together
// under a lock.
// Optional build macro MEM_ARB_STATS_EN adds the xfer/stall/lock counters.
//
// Handshake: a requester holds its REN/WEN and address (and store data) high
// until it samples its wait line low. The wait line is low for exactly the
// cycle in which the RAM completes that requester's word (ramready=1). Read
// data is on the load bus in that same cycle and holds its value afterwards.
// A requester that drops its request before completion abandons the access.
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic                   ramready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]            xfer_count,
  output logic [31:0]            stall_count,
  output logic [31:0]            lock_count
`endif
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  // Complete arbiter state in one struct so checkers can bind to it directly.
  typedef struct packed {
    state_t        state;
    logic          gnt_d;    // 1: dcache grantee, 0: icache grantee
    logic [CW-1:0] gnt_cpu;
    logic [CW-1:0] rr_ptr;
    logic          lock;
  } arb_t;

  arb_t st;

  logic [CPUS-1:0][31:0] iload_q, dload_q;

  // Round-robin search: first set request at or after ptr, wrapping.
  function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [CW-1:0] ptr);
    logic          found;
    logic [CW-1:0] idx;
    logic [CW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CPUS; k++) begin
      cand = CW'((int'(ptr) + k) % CPUS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  logic          wr_any, rd_any, i_any;
  logic [CW-1:0] wr_idx, rd_idx, i_idx;

  // Per-class winners; a dcache with both strobes is a write only.
  always_comb begin
    {wr_any, wr_idx} = rr_pick(dWEN, st.rr_ptr);
    {rd_any, rd_idx} = rr_pick(dREN & ~dWEN, st.rr_ptr);
    {i_any, i_idx}   = rr_pick(iREN, st.rr_ptr);
  end

  logic [CW-1:0] g;
  logic          g_ren, g_wen, g_live, in_access, done, relock;
  logic [CW-1:0] next_ptr;

  // Live view of the grantee; done marks the completing cycle of a word.
  always_comb begin
    g         = st.gnt_cpu;
    g_wen     = st.gnt_d & dWEN[g];
    g_ren     = st.gnt_d ? (dREN[g] & ~dWEN[g]) : iREN[g];
    g_live    = g_ren | g_wen;
    in_access = (st.state == ACCESS) & ~RST;
    done      = in_access & g_live & ramready;
    relock    = st.gnt_d & ~daddr[g][2];
    next_ptr  = CW'((int'(g) + 1) % CPUS);
  end

  // RAM side follows the grantee's live inputs while in ACCESS.
  always_comb begin
    ramREN   = in_access & g_ren;
    ramWEN   = in_access & g_wen;
    ramaddr  = in_access ? (st.gnt_d ? daddr[g] : iaddr[g]) : 32'h0;
    ramstore = (in_access & st.gnt_d) ? dstore[g] : 32'h0;
  end

  // Wait lines and load buses: only the grantee sees a completion.
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = iload_q;
    dload = dload_q;
    for (int c = 0; c < CPUS; c++) begin
      if (done && g == CW'(c)) begin
        if (st.gnt_d) begin
          dwait[c] = 1'b0;
          if (g_ren) dload[c] = ramload;
        end else begin
          iwait[c] = 1'b0;
          iload[c] = ramload;
        end
      end
    end
  end

  // Arbitration / access FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= '{state: IDLE, gnt_d: 1'b0, gnt_cpu: '0, rr_ptr: '0, lock: 1'b0};
    end else begin
      case (st.state)
        IDLE: begin
          if (wr_any) begin
            st.state   <= ACCESS;
            st.gnt_d   <= 1'b1;
            st.gnt_cpu <= wr_idx;
          end else if (rd_any) begin
            st.state   <= ACCESS;
            st.gnt_d   <= 1'b1;
            st.gnt_cpu <= rd_idx;
          end else if (i_any) begin
            st.state   <= ACCESS;
            st.gnt_d   <= 1'b0;
            st.gnt_cpu <= i_idx;
          end
        end
        ACCESS: begin
          if (!g_live) begin
            st.state <= IDLE;
            st.lock  <= 1'b0;
          end else if (ramready) begin
            if (relock) begin
              st.lock <= 1'b1;
            end else begin
              st.lock   <= 1'b0;
              st.rr_ptr <= next_ptr;
              st.state  <= IDLE;
            end
          end
        end
        default: st.state <= IDLE;
      endcase
    end
  end

  // Remember the last word delivered to each requester.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      iload_q <= iload;
      dload_q <= dload;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic stall_pend;

  // Any request pending from someone other than the current grantee.
  always_comb begin
    stall_pend = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (iREN[c] && !(in_access && !st.gnt_d && g == CW'(c))) stall_pend = 1'b1;
      if ((dREN[c] | dWEN[c]) && !(in_access && st.gnt_d && g == CW'(c))) stall_pend = 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xfer_count  <= '0;
      stall_count <= '0;
      lock_count  <= '0;
    end else begin
      if (done && xfer_count != '1) xfer_count <= xfer_count + 32'd1;
      if (stall_pend && stall_count != '1) stall_count <= stall_count + 32'd1;
      if (done && st.lock && !relock && lock_count != '1) lock_count <= lock_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (CPUS=2).
// Expected completions are queued in service order before stimulus starts;
// a negedge monitor pops one entry per observed low wait line.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 68;   // {is_d, cpu[1:0], is_write, data[31:0], addr[31:0]}
  localparam int TMO  = 40;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [CPUS-1:0]       iREN = '0;
  logic [CPUS-1:0][31:0] iaddr = '0;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0]       dREN = '0;
  logic [CPUS-1:0]       dWEN = '0;
  logic [CPUS-1:0][31:0] daddr = '0;
  logic [CPUS-1:0][31:0] dstore = '0;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;
  logic                  ramREN, ramWEN;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic                  ramready;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]           xfer_count, stall_count, lock_count;
`endif

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
`ifdef MEM_ARB_STATS_EN
    , .xfer_count(xfer_count), .stall_count(stall_count), .lock_count(lock_count)
`endif
  );

  // ---------------- RAM model ----------------
  int ram_lat = 1;
  int acc_cnt = 0;

  always_comb begin
    ramready = (ramREN | ramWEN) && (acc_cnt >= ram_lat);
    ramload  = (ramaddr == 32'h40) ? 32'hDEADBEEF : (ramaddr ^ 32'hA5A5_0000);
  end

  always @(posedge CLK) begin
    if (RST || !(ramREN || ramWEN) || ramready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input int c, input bit wr,
                          input logic [31:0] data, input logic [31:0] addr);
    exp_q.push_back({is_d, 2'(c), wr, data, addr});
  endtask

  task automatic observe(input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_xfer actual=%h required=none", got);
    end else begin
      check("xfer", got, exp_q.pop_front());
    end
  endtask

  // Monitor: every low wait line is one completed word.
  always @(negedge CLK) begin
    int lows;
    lows = 0;
    if (!RST) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!iwait[c]) begin
          lows++;
          observe({1'b0, 2'(c), ramWEN, iload[c], ramaddr});
        end
        if (!dwait[c]) begin
          lows++;
          observe({1'b1, 2'(c), ramWEN, ramWEN ? ramstore : dload[c], ramaddr});
        end
      end
      if (lows > 0) check("one_wait_low", W'(lows), W'(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no_completion required=completion", name);
  endtask

  task automatic wait_i(input int c);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < TMO && !seen; n++) begin
      @(negedge CLK);
      seen = !iwait[c];
    end
    if (!seen) timeout("iwait");
  endtask

  task automatic wait_d(input int c);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < TMO && !seen; n++) begin
      @(negedge CLK);
      seen = !dwait[c];
    end
    if (!seen) timeout("dwait");
  endtask

  task automatic i_req(input int c, input logic [31:0] a);
    iaddr[c] = a;
    iREN[c]  = 1'b1;
    wait_i(c);
    @(posedge CLK); #1;
    iREN[c] = 1'b0;
  endtask

  task automatic d_req(input int c, input bit wr, input logic [31:0] a, input logic [31:0] data);
    daddr[c]  = a;
    dstore[c] = data;
    dWEN[c]   = wr;
    dREN[c]   = ~wr;
    wait_d(c);
    @(posedge CLK); #1;
    dWEN[c] = 1'b0;
    dREN[c] = 1'b0;
  endtask

  // Two words with the request held continuously between them.
  task automatic d_pair(input int c, input logic [31:0] a0, input logic [31:0] a1);
    daddr[c] = a0;
    dREN[c]  = 1'b1;
    wait_d(c);
    @(posedge CLK); #1;
    daddr[c] = a1;
    wait_d(c);
    @(posedge CLK); #1;
    dREN[c] = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", W'(iwait), W'(2'b11));
    check("rst_dwait", W'(dwait), W'(2'b11));
    check("rst_iload", W'(iload), W'(0));
    check("rst_dload", W'(dload), W'(0));
    check("rst_ramren", W'(ramREN), W'(0));
    check("rst_ramwen", W'(ramWEN), W'(0));
    check("rst_ramaddr", W'(ramaddr), W'(0));
    check("rst_ramstore", W'(ramstore), W'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    // Single icache read, RAM takes two ACCESS cycles
    ram_lat = 1;
    push_exp(1'b0, 0, 1'b0, 32'hDEADBEEF, 32'h40);
    fork
      i_req(0, 32'h40);
      begin
        @(negedge CLK);
        check("t1_idle_ramren", W'(ramREN), W'(0));
        @(negedge CLK);
        check("t1_acc_ramren", W'(ramREN), W'(1));
        check("t1_acc_ramaddr", W'(ramaddr), W'(32'h40));
        check("t1_acc_iwait", W'(iwait[0]), W'(1));
      end
    join
    @(negedge CLK);
    check("t1_iload_hold", W'(iload[0]), W'(32'hDEADBEEF));
    check("t1_iwait_back", W'(iwait[0]), W'(1));

    // dcache block fetch on cpu1; icache0 raised mid-pair must wait
    @(posedge CLK); #1;
    ram_lat = 0;
    push_exp(1'b1, 1, 1'b0, 32'hA5A50100, 32'h100);
    push_exp(1'b1, 1, 1'b0, 32'hA5A50104, 32'h104);
    push_exp(1'b0, 0, 1'b0, 32'hA5A50048, 32'h48);
    fork
      d_pair(1, 32'h100, 32'h104);
      begin
        wait_d(1);
        @(posedge CLK); #1;
        i_req(0, 32'h48);
      end
      begin
        wait_d(1);
        @(negedge CLK);
        check("t2_second_word_next", W'(dwait[1]), W'(0));
        check("t2_icache_held", W'(iwait[0]), W'(1));
      end
    join

    // Class priority: dWEN[0], dREN[1], iREN[1] raised together
    @(posedge CLK); #1;
    ram_lat = 1;
    push_exp(1'b1, 0, 1'b1, 32'h12345678, 32'h208);
    push_exp(1'b1, 1, 1'b0, 32'hA5A5030C, 32'h30C);
    push_exp(1'b0, 1, 1'b0, 32'hA5A50044, 32'h44);
    fork
      d_req(0, 1'b1, 32'h208, 32'h12345678);
      d_req(1, 1'b0, 32'h30C, 32'h0);
      i_req(1, 32'h44);
    join

    // Round-robin between two dcaches with single-word addresses
    @(posedge CLK); #1;
    ram_lat = 0;
    push_exp(1'b1, 0, 1'b0, 32'hA5A50014, 32'h14);
    push_exp(1'b1, 1, 1'b0, 32'hA5A50024, 32'h24);
    push_exp(1'b1, 0, 1'b0, 32'hA5A5001C, 32'h1C);
    push_exp(1'b1, 1, 1'b0, 32'hA5A5002C, 32'h2C);
    fork
      d_pair(0, 32'h14, 32'h1C);
      d_pair(1, 32'h24, 32'h2C);
    join

    // Abort: grantee drops dREN before ramready
    @(posedge CLK); #1;
    ram_lat = 5;
    daddr[0] = 32'h60;
    dREN[0]  = 1'b1;
    repeat (2) @(negedge CLK);
    check("ab_ramren", W'(ramREN), W'(1));
    @(posedge CLK); #1;
    dREN[0] = 1'b0;
    @(negedge CLK);
    check("ab_ramren_drop", W'(ramREN), W'(0));
    check("ab_dwait", W'(dwait), W'(2'b11));
    repeat (2) @(negedge CLK);
    ram_lat = 0;
    push_exp(1'b0, 1, 1'b0, 32'hA5A5004C, 32'h4C);
    i_req(1, 32'h4C);

    // Reset in the middle of an access
    @(posedge CLK); #1;
    ram_lat = 5;
    daddr[1] = 32'h70;
    dREN[1]  = 1'b1;
    repeat (2) @(negedge CLK);
    check("mr_ramren", W'(ramREN), W'(1));
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    dREN[1] = 1'b0;
    @(negedge CLK);
    check("mr_iwait", W'(iwait), W'(2'b11));
    check("mr_dwait", W'(dwait), W'(2'b11));
    check("mr_ramren_off", W'(ramREN), W'(0));
    check("mr_ramwen_off", W'(ramWEN), W'(0));
    check("mr_iload", W'(iload), W'(0));
    check("mr_dload", W'(dload), W'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

`ifdef MEM_ARB_STATS_EN
    // One locked block plus one icache word
    ram_lat = 0;
    push_exp(1'b1, 0, 1'b0, 32'hA5A50200, 32'h200);
    push_exp(1'b1, 0, 1'b0, 32'hA5A50204, 32'h204);
    push_exp(1'b0, 1, 1'b0, 32'hA5A50050, 32'h50);
    d_pair(0, 32'h200, 32'h204);
    i_req(1, 32'h50);
    @(negedge CLK);
    check("st_xfer_count", W'(xfer_count), W'(3));
    check("st_lock_count", W'(lock_count), W'(1));
`endif

    repeat (3) @(negedge CLK);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
